bcd_to_bin_seq: RTL
===================

// Module: bcd_to_bin_seq
// PURPOSE
//   Iterative BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3
//   from every BCD nibble >= 8. It is the inverse of the combinational binary-to-BCD (add-3)
//   display path. It turns operator/score digits entered as BCD back into binary for game logic.
//   Start/done handshake; one shift-and-correct step per clock.
// PARAMETERS
//   DIGITS  3   number of packed BCD digits on bcd_in (digit 0 = bcd_in[3:0])
//   BIN_W   10  binary result width; 2**BIN_W should exceed 10**DIGITS-1 (else see ovf)
// PORTS
//   clk     in   1          system clock, rising edge
//   rst_n   in   1          asynchronous, active-low reset
//   start   in   1          conversion request; sampled only in IDLE
//   bcd_in  in   4*DIGITS   packed BCD operand; captured on accepted start
//   busy    out  1          conversion in progress
//   done    out  1          one-cycle pulse: bin/ovf/err valid
//   bin     out  BIN_W      binary result; held until next accepted start
//   ovf     out  1          value did not fit in BIN_W bits
//   err     out  1          illegal BCD digit (>9) detected (BCD_VALIDATE_EN only)
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE; busy=0, done=0, bin=0, ovf=0, err=0.
//   - Working register {bcd_r[4*DIGITS-1:0], bin_r[BIN_W-1:0]}; shift counter cnt, width clog2(BIN_W+1).
//   - FSM IDLE -> SHIFT -> DONE -> IDLE.
//     IDLE: start=1 -> bcd_r<=bcd_in, bin_r<=0, cnt<=0, busy<=1, ovf/err<=0, go SHIFT.
//     SHIFT, each cycle:
//       * whole register shifts right by 1; bcd_r LSB enters bin_r MSB;
//       * then each shifted nibble that is >= 8 has 3 subtracted (mod-16, per nibble, no carry);
//       * cnt++; after BIN_W steps go DONE.
//     DONE: bin<=bin_r, ovf<=(bcd_r!=0), busy<=0, done<=1 for exactly one cycle, go IDLE.
//   - Latency: start sampled in cycle 0; done=1 in cycle BIN_W+1; bin valid in the same cycle.
//     Next start is accepted in the cycle after done.
//   - start while busy or done=1 is ignored: no queueing, no effect on the current result.
//   - start held high continuously causes back-to-back conversions, one every BIN_W+2 cycles.
//   - bin/ovf/err keep their last values through IDLE. They are cleared only by reset or an accepted start.
//   - ovf=1 -> bin = value mod 2**BIN_W.
//   - rst_n low mid-conversion: abort immediately, all outputs to reset values, no done pulse.
// CONFIGURATION
//   BCD_VALIDATE_EN defined:
//     - On accepted start, any bcd_in nibble > 9 sets err=1.
//     - FSM goes straight to DONE: done pulses in cycle 1, bin=0, ovf=0, busy high for one cycle.
//   BCD_VALIDATE_EN undefined:
//     - No check; err tied 0.
//     - Illegal digits are converted by the same algorithm; the result is deterministic but unspecified.
// TESTING
//   1 bcd_in=12'h999, start 1 cycle -> busy 1 for 10 cycles, done in cycle 11, bin=10'd999, ovf=0.
//   2 bcd_in=12'h000 -> bin=0, ovf=0. bcd_in=12'h001 -> bin=1.
//     Sweep 0..999 against a reference model: all match.
//   3 start pulsed again at cycle 4 of a 12'h123 conversion -> ignored; bin=123, single done pulse.
//   4 rst_n low at cycle 5 of a 12'h456 conversion -> outputs 0 immediately, no done pulse;
//     after release, 12'h078 -> bin=78.
//   5 DIGITS=3, BIN_W=8, bcd_in=12'h256 -> done at cycle 9, bin=8'd0, ovf=1.
//     With bcd_in=12'h255 -> bin=255, ovf=0.
//   6 BCD_VALIDATE_EN, bcd_in=12'h0A5 -> done in cycle 1, err=1, bin=0.
//     Without the macro: err=0, done in cycle 11.

Source files
------------

// File: rtl/bcd_to_bin_seq_if.sv
// Start/done handshake bundle for the sequential BCD-to-binary converter.
// master drives the request, slave (the converter) returns status and result.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin;
  logic                  ovf;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin, ovf, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin, ovf, err
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter (reverse double-dabble: shift right, then -3 on nibbles >= 8).
// Optional macro BCD_VALIDATE_EN: reject operands with a digit > 9 (err=1, immediate done).
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_to_bin_seq_if.slave   s
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg;
  logic [BW-1:0]      bcd_reg;
  logic [BIN_W-1:0]   work_reg;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic               ovf_reg;

  logic [BW+BIN_W-1:0] cat_sh;
  logic [BW-1:0]       bcd_next;
  logic [BIN_W-1:0]    work_next;

  // One step: shift the whole working register right, then correct each BCD nibble.
  assign cat_sh    = {bcd_reg, work_reg} >> 1;
  assign work_next = cat_sh[BIN_W-1:0];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
    logic [3:0] nib;
    assign nib = cat_sh[BIN_W + 4*gi +: 4];
    assign bcd_next[4*gi +: 4] = nib[3] ? nib - 4'd3 : nib;
  end

`ifdef BCD_VALIDATE_EN
  logic err_reg;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (s.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      bcd_reg   <= '0;
      work_reg  <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      bin_reg   <= '0;
      ovf_reg   <= 1'b0;
`ifdef BCD_VALIDATE_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (s.start) begin
            bcd_reg  <= s.bcd_in;
            work_reg <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
            bin_reg  <= '0;
            ovf_reg  <= 1'b0;
`ifdef BCD_VALIDATE_EN
            err_reg  <= bad_digit;
            if (bad_digit) begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              state_reg <= SHIFT;
            end
`else
            state_reg <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          bcd_reg  <= bcd_next;
          work_reg <= work_next;
          cnt_reg  <= cnt_reg + 1'b1;
          // Publish on the final step so done lands BIN_W+1 cycles after start.
          if (cnt_reg == LAST) begin
            bin_reg   <= work_next;
            ovf_reg   <= |bcd_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign s.busy = busy_reg;
  assign s.done = done_reg;
  assign s.bin  = bin_reg;
  assign s.ovf  = ovf_reg;
`ifdef BCD_VALIDATE_EN
  assign s.err  = err_reg;
`else
  assign s.err  = 1'b0;
`endif

endmodule
